cpu_control_unit: RTL and testbench

CPU_CONTROL_UNIT -- requirements
Module: cpu_control_unit

---
 rtl/cpu_control_unit.sv | 98 +++++++++
 tb/tb_cpu_control_unit.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/cpu_control_unit.sv
// cpu_control_unit: multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer with registered outputs.
// Define CPU_CTRL_WATCHDOG_EN to add a 16-cycle memory-wait watchdog and the FAULT state.
module cpu_control_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  Opcode,
    input  logic        BEQ,
    input  logic [12:0] newPC,
    input  logic        memDone,
    output logic        read,
    output logic        write,
    output logic        instruction,
    output logic        instructionType,
    output logic [2:0]  ALU_Op,
    output logic [12:0] PC,
    output logic        writeFlag,
    output logic        fault
);
    typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, FAULT} state_t;
    state_t state, nxt;
    logic [2:0] opq, op, alu_d;
    logic [12:0] pc_d;
    logic it_d, done;
    // memDone only counts while one of our own requests is outstanding
    assign done = memDone & (read | write);
    assign op = (state == DECODE) ? Opcode : opq;
    assign alu_d = (op == 3'b010) ? 3'd2 : (op == 3'b011) ? 3'd3 :
                   (op == 3'b001 || op == 3'b111) ? 3'd1 : 3'd0;
    assign it_d = !(op inside {3'b100, 3'b101, 3'b110});
`ifdef CPU_CTRL_WATCHDOG_EN
    logic [3:0] wd;
    logic waiting, timeout;
    assign waiting = (state == FETCH || state == MEM) && (read || write);
    assign timeout = waiting && !memDone && wd == 4'hf;
`endif
    always_comb begin
        nxt = state;
        pc_d = PC;
        case (state)
            FETCH:  nxt = done ? DECODE : FETCH;
            DECODE: nxt = EXEC;
            EXEC: begin
                nxt = (op == 3'b111) ? FETCH : (op == 3'b101 || op == 3'b110) ? MEM : WB;
                if (op == 3'b111) pc_d = BEQ ? newPC : PC + 13'd1;
            end
            MEM: begin
                if (done) nxt = (op == 3'b101) ? WB : FETCH;
                if (done && op == 3'b110) pc_d = PC + 13'd1;
            end
            WB: begin
                nxt = FETCH;
                pc_d = PC + 13'd1;
            end
            default: nxt = state;
        endcase
`ifdef CPU_CTRL_WATCHDOG_EN
        if (timeout) nxt = FAULT;
`endif
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= FETCH;
            PC <= '0;
            opq <= '0;
            read <= 1'b0;
            write <= 1'b0;
            instruction <= 1'b0;
            instructionType <= 1'b0;
            ALU_Op <= '0;
            writeFlag <= 1'b0;
        end else begin
            state <= nxt;
            PC <= pc_d;
            if (state == DECODE) opq <= Opcode;
            read <= nxt == FETCH || (nxt == MEM && op == 3'b101);
            write <= nxt == MEM && op == 3'b110;
            instruction <= nxt == FETCH;
            writeFlag <= nxt == WB;
            if (nxt == EXEC) begin
                ALU_Op <= alu_d;
                instructionType <= it_d;
            end
        end
    end
`ifdef CPU_CTRL_WATCHDOG_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wd <= '0;
            fault <= 1'b0;
        end else begin
            wd <= (waiting && nxt == state) ? wd + 4'd1 : 4'd0;
            fault <= nxt == FAULT;
        end
    end
`else
    assign fault = 1'b0;
`endif
endmodule

// File: tb/tb_cpu_control_unit.sv
// tb_cpu_control_unit: directed + random instruction sequences checked against a transaction-level model.
module tb_cpu_control_unit;
    logic clk, reset, BEQ, memDone;
    logic [2:0] Opcode, ALU_Op;
    logic [12:0] newPC, PC, pc_m;
    logic read, write, instruction, instructionType, writeFlag, fault;
    int n_chk = 0, n_fail = 0;
    logic [2:0] alu_tab [8] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd0, 3'd0, 3'd0, 3'd1};
    logic it_tab [8] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};

    cpu_control_unit dut (
        .clk(clk), .reset(reset), .Opcode(Opcode), .BEQ(BEQ), .newPC(newPC),
        .memDone(memDone), .read(read), .write(write), .instruction(instruction),
        .instructionType(instructionType), .ALU_Op(ALU_Op), .PC(PC),
        .writeFlag(writeFlag), .fault(fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Fetch phase: request held for w idle cycles, then completed.
    task automatic fetch(input int w);
        for (int i = 0; i < w; i++) begin
            chk("fetch_req", {read, instruction, write}, 3'b110);
            step;
        end
        memDone = 1'b1;
        chk("fetch_req", {read, instruction, write}, 3'b110);
        chk("fetch_pc", PC, pc_m);
        step;
        memDone = 1'b0;
    endtask

    // One complete instruction, starting just after FETCH is entered.
    task automatic run(input logic [2:0] op, input int fw, input int mw, input logic bf, input logic [12:0] np);
        Opcode = op;
        fetch(fw);
        memDone = 1'($urandom_range(0, 1));
        chk("decode_idle", {read, write, writeFlag}, 3'b000);
        step;
        memDone = 1'b0;
        chk("exec_alu", ALU_Op, alu_tab[op]);
        chk("exec_itype", instructionType, it_tab[op]);
        chk("exec_idle", {read, write, writeFlag}, 3'b000);
        BEQ = bf;
        newPC = np;
        memDone = 1'($urandom_range(0, 1));
        step;
        memDone = 1'b0;
        if (op == 3'd7) pc_m = bf ? np : pc_m + 13'd1;
        else begin
            if (op == 3'd5 || op == 3'd6) begin
                for (int i = 0; i <= mw; i++) begin
                    chk("mem_req", {read, write, instruction, writeFlag}, {op == 3'd5, op == 3'd6, 2'b00});
                    chk("mem_alu_hold", ALU_Op, alu_tab[op]);
                    if (i == mw) memDone = 1'b1;
                    step;
                end
                memDone = 1'b0;
            end
            if (op != 3'd6) begin
                chk("wb_flag", {writeFlag, read, write}, 3'b100);
                chk("wb_alu_hold", {instructionType, ALU_Op}, {it_tab[op], alu_tab[op]});
                memDone = 1'($urandom_range(0, 1));
                step;
                memDone = 1'b0;
            end
            pc_m = pc_m + 13'd1;
        end
        chk("next_fetch", {writeFlag, read, instruction}, 3'b011);
        chk("next_pc", PC, pc_m);
    endtask

    initial begin
        reset = 1'b0;
        {BEQ, memDone, Opcode, newPC} = '0;
        pc_m = '0;
        repeat (2) step;
        chk("reset_outs", {read, write, instruction, instructionType, ALU_Op, writeFlag, fault}, 0);
        chk("reset_pc", PC, 0);
        reset = 1'b1;
        step;
        chk("first_fetch", {read, instruction, write}, 3'b110);
        run(3'd0, 1, 0, 1'b0, 0);
        run(3'd0, 0, 0, 1'b0, 0);
        run(3'd7, 0, 0, 1'b1, 13'h0a5);
        run(3'd7, 1, 0, 1'b0, 13'h155);
        run(3'd1, 0, 0, 1'b0, 0);
        run(3'd2, 2, 0, 1'b0, 0);
        run(3'd3, 0, 0, 1'b0, 0);
        run(3'd4, 0, 0, 1'b0, 0);
        run(3'd5, 1, 2, 1'b0, 0);
        run(3'd7, 0, 0, 1'b1, 13'h1fff);
        run(3'd6, 0, 3, 1'b0, 0);
        chk("st_wrap_pc", PC, 0);
        // Reset pulsed while an LD is waiting in MEM.
        Opcode = 3'd5;
        fetch(0);
        step;
        step;
        chk("ld_mem_req", {read, write, instruction}, 3'b100);
        step;
        reset = 1'b0;
        #1;
        chk("abort_outs", {read, write, instruction, instructionType, ALU_Op, writeFlag, fault}, 0);
        chk("abort_pc", PC, 0);
        memDone = 1'b1;
        step;
        reset = 1'b1;
        step;
        memDone = 1'b0;
        chk("restart_fetch", {read, instruction, write}, 3'b110);
        step;
        chk("stale_done_ignored", {read, instruction}, 2'b11);
        pc_m = '0;
        for (int k = 0; k < 40; k++)
            run(3'($urandom_range(0, 7)), $urandom_range(0, 3), $urandom_range(0, 3),
                1'($urandom_range(0, 1)), 13'($urandom));
        reset = 1'b0;
        #1;
        step;
        reset = 1'b1;
        step;
`ifdef CPU_CTRL_WATCHDOG_EN
        for (int i = 0; i < 16; i++) begin
            chk("wd_wait", {read, fault}, 2'b10);
            step;
        end
        chk("wd_fault", {fault, read, write, instruction, writeFlag}, 5'b10000);
        memDone = 1'b1;
        step;
        memDone = 1'b0;
        step;
        chk("wd_sticky", {fault, read}, 2'b10);
        reset = 1'b0;
        #1;
        chk("wd_reset_clears", fault, 0);
        reset = 1'b1;
        step;
        chk("wd_refetch", {read, instruction, fault}, 3'b110);
`else
        for (int i = 0; i < 24; i++) begin
            chk("no_wd_wait", {read, instruction, fault}, 3'b110);
            step;
        end
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
